// File: rtl/noc_output_allocator.sv
// rtl/noc_output_allocator.sv - round-robin wormhole switch allocator with credit gating for one NoC output
module noc_output_allocator #(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 2,
   parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
   parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
   input  logic                    clk_noc,
   input  logic                    rst_noc_sync,
   input  logic [NUM_INPUTS-1:0]   req,
   input  logic [NUM_INPUTS-1:0]   req_is_tail,
   input  logic [NUM_INPUTS-1:0]   turn_mask,
   input  logic                    credit_in,
   output logic [NUM_INPUTS-1:0]   grant,
   output logic [IDX_WIDTH-1:0]    grant_idx,
   output logic                    send_out,
   output logic                    locked,
   output logic [CREDIT_WIDTH-1:0] credit_count,
   output logic                    credit_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = CREDIT_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(NUM_INPUTS - 1);

   state_t                state, next_state;
   logic [IDX_WIDTH-1:0]  owner, next_owner;
   logic [IDX_WIDTH-1:0]  rr_ptr, next_rr_ptr;
   logic [NUM_INPUTS-1:0] elig;
   logic [IDX_WIDTH-1:0]  winner;
   logic [IDX_WIDTH-1:0]  cand;
   logic                  found;
   logic                  has_credit;

   // Round-robin search starts one past the last winner and wraps.
   always_comb begin
      elig   = req & ~turn_mask;
      found  = 1'b0;
      winner = rr_ptr;
      cand   = rr_ptr;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_INPUTS);
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign has_credit = (credit_count != '0);

   always_comb begin
      grant       = '0;
      grant_idx   = rr_ptr;
      next_state  = state;
      next_owner  = owner;
      next_rr_ptr = rr_ptr;
      if (rst_noc_sync) begin
         grant_idx = LAST_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (has_credit && found) begin
                  grant[winner] = 1'b1;
                  grant_idx     = winner;
                  next_rr_ptr   = winner;
                  if (!req_is_tail[winner]) begin
                     next_state = LOCKED;
                     next_owner = winner;
                  end
               end
            end
            LOCKED: begin
               // Owner keeps the output even if it bubbles or its turn gets masked.
               grant_idx = owner;
               if (req[owner] && has_credit) begin
                  grant[owner] = 1'b1;
                  if (req_is_tail[owner]) begin
                     next_state = IDLE;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   assign send_out = |grant;
   assign locked   = (state == LOCKED) && !rst_noc_sync;

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= LAST_IDX;
      end else begin
         state  <= next_state;
         owner  <= next_owner;
         rr_ptr <= next_rr_ptr;
      end
   end

   // A credit arriving with the counter already full is dropped and flagged.
   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         credit_count <= CREDIT_FULL;
         credit_err   <= 1'b0;
      end else if (credit_in && !send_out) begin
         if (credit_count == CREDIT_FULL) begin
            credit_err <= 1'b1;
         end else begin
            credit_count <= credit_count + CREDIT_ONE;
         end
      end else if (send_out && !credit_in) begin
         credit_count <= credit_count - CREDIT_ONE;
      end
   end

endmodule

// File: tb/tb_noc_output_allocator.sv
// tb/tb_noc_output_allocator.sv - directed self-checking bench for noc_output_allocator
module tb_noc_output_allocator;

   logic       clk_noc = 1'b0;
   logic       rst_noc_sync;
   logic [4:0] req, req_is_tail, turn_mask;
   logic       credit_in;
   logic [4:0] grant;
   logic [2:0] grant_idx;
   logic       send_out, locked;
   logic [1:0] credit_count;
   logic       credit_err;

   int checks = 0;
   int failures = 0;

   noc_output_allocator dut (
      .clk_noc      (clk_noc),
      .rst_noc_sync (rst_noc_sync),
      .req          (req),
      .req_is_tail  (req_is_tail),
      .turn_mask    (turn_mask),
      .credit_in    (credit_in),
      .grant        (grant),
      .grant_idx    (grant_idx),
      .send_out     (send_out),
      .locked       (locked),
      .credit_count (credit_count),
      .credit_err   (credit_err)
   );

   always #5 clk_noc = ~clk_noc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_noc);
      #1;
   endtask

   task automatic mid;
      @(negedge clk_noc);
   endtask

   logic [4:0] rr_exp [6];

   initial begin
      rst_noc_sync = 1'b1;
      req = '0; req_is_tail = '0; turn_mask = '0; credit_in = 1'b0;
      step;
      // Reset state; a request during reset must not be granted
      req = 5'b00001; req_is_tail = 5'b11111;
      mid;
      chk("rst_grant", grant, 5'b00000);
      chk("rst_send", send_out, 0);
      chk("rst_locked", locked, 0);
      chk("rst_idx", grant_idx, 4);
      chk("rst_credit", credit_count, 2);
      chk("rst_err", credit_err, 0);
      step;

      // Single tail flit from input 0, same-cycle grant
      rst_noc_sync = 1'b0;
      mid;
      chk("t1_grant", grant, 5'b00001);
      chk("t1_send", send_out, 1);
      chk("t1_idx", grant_idx, 0);
      step;
      req = '0;
      mid;
      chk("t1_credit", credit_count, 1);
      chk("t1_locked", locked, 0);
      chk("t1_rrptr", grant_idx, 0);
      chk("t1_nogrant", grant, 5'b00000);
      credit_in = 1'b1;
      step;
      credit_in = 1'b0;
      mid;
      chk("t1_refill", credit_count, 2);
      step;

      // Round robin among 1, 2, 4 with credits replenished every cycle
      rr_exp = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};
      req = 5'b10110; req_is_tail = 5'b11111; credit_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mid;
         chk($sformatf("t2_rr%0d", i), grant, rr_exp[i]);
         step;
      end
      req = '0; credit_in = 1'b0;
      mid;
      chk("t2_credit", credit_count, 2);
      chk("t2_rrptr", grant_idx, 4);
      step;

      // Input 3 holds the output for a 4-flit packet while input 1 waits
      credit_in = 1'b1;
      req = 5'b01000; req_is_tail = 5'b00000;
      mid;
      chk("t3_head", grant, 5'b01000);
      chk("t3_head_lock", locked, 0);
      step;
      req = 5'b01010;
      for (int i = 1; i < 4; i++) begin
         req_is_tail = (i == 3) ? 5'b01000 : 5'b00000;
         mid;
         chk($sformatf("t3_flit%0d", i), grant, 5'b01000);
         chk($sformatf("t3_lock%0d", i), locked, 1);
         chk($sformatf("t3_idx%0d", i), grant_idx, 3);
         step;
      end
      req = 5'b00010; req_is_tail = 5'b00010;
      mid;
      chk("t3_next", grant, 5'b00010);
      chk("t3_unlock", locked, 0);
      step;
      req = '0; credit_in = 1'b0;
      mid;
      chk("t3_credit", credit_count, 2);
      step;

      // Credit starvation mid-packet from input 0
      req = 5'b00001; req_is_tail = 5'b00000;
      mid;
      chk("t4_f1", grant, 5'b00001);
      step;
      mid;
      chk("t4_f2", grant, 5'b00001);
      step;
      req_is_tail = 5'b00001;
      mid;
      chk("t4_stall_send", send_out, 0);
      chk("t4_stall_cnt", credit_count, 0);
      chk("t4_stall_lock", locked, 1);
      step;
      credit_in = 1'b1;
      mid;
      chk("t4_stall2_send", send_out, 0);
      step;
      credit_in = 1'b0;
      mid;
      chk("t4_tail", grant, 5'b00001);
      chk("t4_tail_cnt", credit_count, 1);
      step;
      req = '0;
      mid;
      chk("t4_end_cnt", credit_count, 0);
      chk("t4_end_lock", locked, 0);
      step;

      // Simultaneous credit and send, then overflow
      credit_in = 1'b1;
      step;
      req = 5'b00001; req_is_tail = 5'b00001;
      mid;
      chk("t5_send", send_out, 1);
      chk("t5_cnt_before", credit_count, 1);
      step;
      req = '0;
      mid;
      chk("t5_cnt_same", credit_count, 1);
      step;
      mid;
      chk("t5_cnt_full", credit_count, 2);
      chk("t5_err_clear", credit_err, 0);
      step;
      credit_in = 1'b0;
      mid;
      chk("t5_cnt_sat", credit_count, 2);
      chk("t5_err_set", credit_err, 1);
      step;
      mid;
      chk("t5_err_sticky", credit_err, 1);
      step;

      // Reset mid-packet aborts the lock; masked input 2 never wins
      req = 5'b00001; req_is_tail = 5'b00000;
      step;
      mid;
      chk("t6_locked", locked, 1);
      chk("t6_cnt", credit_count, 1);
      turn_mask = 5'b00100; req = 5'b00100; rst_noc_sync = 1'b1;
      mid;
      chk("t6_rst_grant", grant, 5'b00000);
      step;
      rst_noc_sync = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid;
         chk($sformatf("t6_mask%0d", i), grant, 5'b00000);
         chk($sformatf("t6_cnt%0d", i), credit_count, 2);
         chk($sformatf("t6_lock%0d", i), locked, 0);
         step;
      end
      mid;
      chk("t6_err_cleared", credit_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_output_allocator.md
# noc_output_allocator

Per-output-port switch allocator for the NoC router. It arbitrates among the router's input ports competing for one output port, using round-robin priority. It holds the output for the winning input for a whole wormhole packet, up to and including the tail flit. It gates every flit transfer on a credit counter that tracks free slots in the downstream input FIFO. One instance sits beside each output of the crossbar and drives that output's select and `send_out`.

## Interface

Parameters:

- `NUM_INPUTS`, default 5: number of requesting input ports (port 0 = local injection).
- `FLIT_BUFFER_DEPTH`, default 2: downstream FIFO depth; initial and maximum credit count.
- `CREDIT_WIDTH`, default `$clog2(FLIT_BUFFER_DEPTH+1)`: width of the credit counter.
- `IDX_WIDTH`, default `$clog2(NUM_INPUTS)`: width of the grant index.

Ports:

- `clk_noc`  in  1  NoC clock. The block uses this single clock only.
- `rst_noc_sync`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_INPUTS  input i has a head-of-queue flit routed to this output.
- `req_is_tail`  in  NUM_INPUTS  the flit presented by input i is a tail flit.
- `turn_mask`  in  NUM_INPUTS  1 = turn from input i to this output is disabled.
- `credit_in`  in  1  one downstream slot freed (one pulse per flit).
- `grant`  out  NUM_INPUTS  one-hot; input i's flit is transferred this cycle.
- `grant_idx`  out  IDX_WIDTH  crossbar select. Holds the owner while locked, else the last winner.
- `send_out`  out  1  flit valid on this output this cycle; equals `|grant`.
- `locked`  out  1  a multi-flit packet currently owns the output.
- `credit_count`  out  CREDIT_WIDTH  current downstream credits.
- `credit_err`  out  1  sticky flag: `credit_in` was received while the counter was already full.

## Operation

- State machine with two states, IDLE and LOCKED. Registers: `owner` (IDX_WIDTH), `rr_ptr` (IDX_WIDTH), credit counter, `credit_err`.
- Eligible set: `elig = req & ~turn_mask`. `turn_mask` is evaluated only during arbitration in IDLE.
- IDLE, when `credit_count > 0` and `elig != 0`:
  - Winner = first set bit of `elig`, searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_INPUTS.
  - `grant[winner]=1`, `send_out=1`, `rr_ptr <= winner`.
  - If `req_is_tail[winner]=0`: go to LOCKED, `owner <= winner`.
  - If `req_is_tail[winner]=1` (single-flit packet): stay in IDLE.
- IDLE, when `credit_count == 0` or `elig == 0`: `grant = 0`, no state change.
- LOCKED:
  - `grant[owner] = req[owner] && credit_count > 0`. No other input can be granted.
  - A transfer with `req_is_tail[owner]=1` returns the block to IDLE; `rr_ptr` stays equal to `owner`.
  - If the owner drops `req` mid-packet, the output idles (bubble) and stays LOCKED.
  - A change to `turn_mask` does not break the lock.
- Credit arithmetic, every cycle: `next = count - send_out + credit_in`.
  - Simultaneous `send_out` and `credit_in` leave the count unchanged.
  - `credit_in` with `count == FLIT_BUFFER_DEPTH` and no send: count saturates at FLIT_BUFFER_DEPTH and `credit_err <= 1`.
  - `send_out` is never asserted at count 0, so the counter never underflows.
- `grant_idx` = owner in LOCKED, combinational winner on a grant in IDLE, otherwise `rr_ptr`.

## Timing

- `grant`, `send_out` and `grant_idx` are combinational from `req`, `req_is_tail`, `turn_mask` and the registered state. A request is granted in the same cycle it is presented.
- State, `owner`, `rr_ptr` and the credit counter update on the rising edge of `clk_noc` after the transfer.
- A credit returned in cycle N can first be spent in cycle N+1.
- Reset values (applied while `rst_noc_sync=1`): state IDLE, `owner=0`, `rr_ptr=NUM_INPUTS-1` (input 0 has first priority), `credit_count=FLIT_BUFFER_DEPTH`, `credit_err=0`, `locked=0`, `grant=0`, `send_out=0`, `grant_idx=NUM_INPUTS-1`.
- Reset asserted mid-packet aborts the lock: the block returns to IDLE and credits are restored to full on the next edge. During reset, `grant` is forced to 0 regardless of `req`.
- Throughput: one flit per cycle while credits remain. With FLIT_BUFFER_DEPTH=2 and a 1-cycle credit return, sustained rate is 2 flits per 3 cycles.

## Test plan

- Reset, then `req=5'b00001` with tail, single flit → cycle 0: `grant=00001`, `send_out=1`; next cycle `credit_count=1`, `locked=0`, `rr_ptr=0`.
- `req=5'b10110`, every flit a tail, credits replenished each cycle → successive grants go to inputs 1, 2, 4, 1, 2, 4 (round-robin order).
- Input 3 sends a 4-flit packet while input 1 requests continuously → four grants to input 3 with `locked=1` through flit 3. The cycle after the tail, input 1 is granted.
- No `credit_in` with DEPTH=2, 3-flit packet → flits 1 and 2 sent, `send_out=0` at count 0. One `credit_in` pulse → tail sent the following cycle; `credit_count` ends at 0 and `locked=0`.
- `credit_in` and `send_out` in the same cycle at count 1 → count stays 1. `credit_in` at count 2 → count stays 2 and `credit_err=1` (sticky until reset).
- Reset asserted mid-packet with `turn_mask=5'b00100` and `req=5'b00100` → after reset `credit_count=2`, `locked=0`; input 2 is never granted.
